mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits between the execute stage and `wb_stage`. It latches the execute-stage bus and waits for the data-SRAM response of an issued load or store. It then extracts and aligns load data (lb/lbu/lh/lhu/lw/lwl/lwr) and emits the 124-bit `ms_to_ws_bus` that `wb_stage` consumes. It also drives the MEM-stage forwarding/stall signals to decode and discards data responses that belong to flushed instructions.

## Interface
- `ES_TO_MS_BUS_WD`, 160: input bus width. Layout:
  - bit 159: `es_mem_req` (a load or store was accepted by the SRAM, addr_ok seen)
  - bits 158:156: `load_op`
  - bits 155:124: `rt_value`
  - bits 123:0: identical layout to `ms_to_ws_bus`, with the result field holding the ALU result.
- `MS_TO_WS_BUS_WD`, 124: output bus width. Field layout is fixed by `wb_stage`: tlbp/tlbr/tlbwi/tlbwr 123:120, data_sram_addr 119:88, mfc0_rd 87:83, ex 82, ExcCode 81:77, bd 76, eret 75, sel 74:72, mtc0 71, mfc0 70, gr_we 69, dest 68:64, result 63:32, pc 31:0.
- `clk` input 1: clock.
- `resetn` input 1: reset, synchronous, active-low. One clock, `clk`.
- `ws_allowin` input 1: WB stage can accept.
- `ms_allowin` output 1: MEM can accept.
- `es_to_ms_valid` input 1: execute bus valid.
- `es_to_ms_bus` input ES_TO_MS_BUS_WD: execute bus.
- `ms_to_ws_valid` output 1: output bus valid.
- `ms_to_ws_bus` output MS_TO_WS_BUS_WD: output bus.
- `data_sram_data_ok` input 1: data response strobe.
- `data_sram_rdata` input 32: response data.
- `flush` input 1: exception/eret flush from WB.
- `MEM_dest` output 5: forwarding destination, 0 when invalid or gr_we=0.
- `MEM_result` output 32: forwarding data (final load/ALU result).
- `ms_load_stall` output 1: valid load whose data has not arrived; decode must stall.
- `ms_ex_or_eret` output 1: valid MEM instruction has ex=1 or eret=1; execute must suppress new stores.

## Operation
- `load_op` encoding: 0 = no load, 1 = lw, 2 = lb, 3 = lbu, 4 = lh, 5 = lhu, 6 = lwl, 7 = lwr.
- Byte offset `off` = data_sram_addr[1:0].
- State registers:
  - `ms_valid`
  - `bus_r` (ES_TO_MS_BUS_WD)
  - `rdata_buf[31:0]` and `buf_valid`
  - `discard_cnt[1:0]`
- Accept: when `ms_allowin && es_to_ms_valid` and `flush`=0, `bus_r` <= `es_to_ms_bus` and `buf_valid` <= 0. `ms_valid` <= `es_to_ms_valid` whenever `ms_allowin`.
- Effective response: `resp_ok = data_sram_data_ok && discard_cnt==0`.
- `wait_data = ms_valid && es_mem_req && !ex && !buf_valid`.
- `ms_ready_go = !wait_data || resp_ok`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go && !flush`.
- Response buffering:
  - When `wait_data && resp_ok` and `ws_allowin`=0, `rdata_buf` <= rdata and `buf_valid` <= 1.
  - Load data source is `buf_valid ? rdata_buf : data_sram_rdata`.
- Extraction:
  - lb/lbu: byte `off` is sign-/zero-extended.
  - lh/lhu: halfword at addr[1] is sign-/zero-extended.
  - lw: the full word.
  - lwl by off 0..3: {d[7:0],rt[23:0]}, {d[15:0],rt[15:0]}, {d[23:0],rt[7:0]}, d.
  - lwr by off 0..3: d, {rt[31:24],d[31:8]}, {rt[31:16],d[31:16]}, {rt[31:8],d[31:24]}.
  - The result field is replaced by the extracted value when `load_op`≠0; otherwise it is passed unchanged.
- `ms_to_ws_bus` = `bus_r[123:0]` with the result field replaced as above.
- Flush:
  - `ms_valid` <= 0 and `buf_valid` <= 0.
  - `discard_cnt` += 1 if `wait_data && !resp_ok`.
  - `discard_cnt` += 1 more if `es_to_ms_valid && es_mem_req` is being offered that cycle (that request is dropped).
- Every `data_sram_data_ok` with `discard_cnt`≠0 decrements the counter and is ignored.
- When flush and data_ok coincide, the increment and decrement apply together (net).
- `ms_load_stall = ms_valid && load_op!=0 && !ms_ready_go`.

## Timing
- Reset (`resetn`=0 at a clk edge): `ms_valid`=0, `bus_r`=0, `buf_valid`=0, `rdata_buf`=0, `discard_cnt`=0.
- Outputs after reset: `ms_allowin`=1, `ms_to_ws_valid`=0, `MEM_dest`=0, `ms_load_stall`=0, `ms_ex_or_eret`=0.
- Reset mid-transaction abandons any pending response; the SRAM is reset with the core.
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Load: data_ok in the first MEM cycle passes the data to WB in that cycle (combinational rdata-to-bus path); each cycle of later data_ok adds one cycle.
- `discard_cnt` saturates at 3. An overflow is a protocol violation; at most 2 requests are outstanding.
- Flush has priority over accept in the same cycle.

## Test plan
- ALU op (gr_we=1, dest=5, result=0x1234) with ws_allowin=1 -> `ms_to_ws_valid` is 1 the next cycle, result=0x1234, `MEM_dest`=5.
- lb at addr 0x...03 with rdata=0x80FF0011 -> result 0xFFFFFF80. lbu at the same address -> result 0x00000080.
- lwl off=1, rt=0xAABBCCDD, rdata=0x11223344 -> result 0x3344CCDD. lwr off=2 with the same values -> result 0xAABB1122.
- Load with data_ok 3 cycles late -> `ms_load_stall`=1 and `ms_to_ws_valid`=0 for 3 cycles, then valid with correct data. Repeat with ws_allowin=0 at data_ok -> data is held in `rdata_buf` and delivered intact when ws_allowin rises.
- flush while a load waits, with a new load offered from execute -> `discard_cnt`=2. The next two data_ok strobes are ignored, and the third completes the following load.
- `resetn` low for 1 cycle during a pending load -> all outputs take their reset values, and the next instruction proceeds normally.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MIPS MEM stage - waits for data-SRAM responses, aligns load
//             data and drops responses belonging to flushed requests.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 160,
    parameter int MS_TO_WS_BUS_WD = 124
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic [4:0]                 MEM_dest,
    output logic [31:0]                MEM_result,
    output logic                       ms_load_stall,
    output logic                       ms_ex_or_eret
);

    logic                       ms_valid_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;
    logic [31:0]                rdata_buf_q;
    logic                       buf_valid_q;
    logic [1:0]                 discard_cnt_q;
    logic [1:0]                 discard_cnt_d;

    logic        es_mem_req;
    logic [2:0]  load_op;
    logic [31:0] rt_value;
    logic [31:0] addr;
    logic [1:0]  off;
    logic        ex;
    logic        eret;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;

    logic        resp_ok;
    logic        wait_data;
    logic        ms_ready_go;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] final_result;
    logic        inc_wait;
    logic        inc_offer;
    logic        dec_resp;
    logic [2:0]  discard_sum;

    assign es_mem_req = bus_q[159];
    assign load_op    = bus_q[158:156];
    assign rt_value   = bus_q[155:124];
    assign addr       = bus_q[119:88];
    assign off        = addr[1:0];
    assign ex         = bus_q[82];
    assign eret       = bus_q[75];
    assign gr_we      = bus_q[69];
    assign dest       = bus_q[68:64];
    assign alu_result = bus_q[63:32];

    assign resp_ok        = data_sram_data_ok && (discard_cnt_q == 2'd0);
    assign wait_data      = ms_valid_q && es_mem_req && !ex && !buf_valid_q;
    assign ms_ready_go    = !wait_data || resp_ok;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    assign ms_load_stall  = ms_valid_q && (load_op != 3'd0) && !ms_ready_go;
    assign ms_ex_or_eret  = ms_valid_q && (ex || eret);

    assign ld_data = buf_valid_q ? rdata_buf_q : data_sram_rdata;
    assign ld_half = addr[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        ld_byte = ld_data[7:0];
        case (off)
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            2'd3:    ld_byte = ld_data[31:24];
            default: ld_byte = ld_data[7:0];
        endcase
    end

    always_comb begin
        final_result = alu_result;
        case (load_op)
            3'd1: final_result = ld_data;
            3'd2: final_result = {{24{ld_byte[7]}}, ld_byte};
            3'd3: final_result = {24'd0, ld_byte};
            3'd4: final_result = {{16{ld_half[15]}}, ld_half};
            3'd5: final_result = {16'd0, ld_half};
            3'd6: begin
                case (off)
                    2'd0:    final_result = {ld_data[7:0],  rt_value[23:0]};
                    2'd1:    final_result = {ld_data[15:0], rt_value[15:0]};
                    2'd2:    final_result = {ld_data[23:0], rt_value[7:0]};
                    default: final_result = ld_data;
                endcase
            end
            3'd7: begin
                case (off)
                    2'd0:    final_result = ld_data;
                    2'd1:    final_result = {rt_value[31:24], ld_data[31:8]};
                    2'd2:    final_result = {rt_value[31:16], ld_data[31:16]};
                    default: final_result = {rt_value[31:8],  ld_data[31:24]};
                endcase
            end
            default: final_result = alu_result;
        endcase
    end

    assign ms_to_ws_bus = {bus_q[123:64], final_result, bus_q[31:0]};
    assign MEM_result   = final_result;
    assign MEM_dest     = (ms_valid_q && gr_we) ? dest : 5'd0;

    // A flush can orphan the waiting request and the one being offered;
    // their responses must be swallowed before any new data is trusted.
    assign inc_wait    = flush && wait_data && !resp_ok;
    assign inc_offer   = flush && es_to_ms_valid && es_to_ms_bus[159];
    assign dec_resp    = data_sram_data_ok && (discard_cnt_q != 2'd0);
    assign discard_sum = {1'b0, discard_cnt_q} + {2'b0, inc_wait}
                       + {2'b0, inc_offer} - {2'b0, dec_resp};

    always_comb begin
        discard_cnt_d = discard_sum[1:0];
        if (discard_sum > 3'd3) begin
            discard_cnt_d = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            bus_q         <= '0;
            rdata_buf_q   <= 32'd0;
            buf_valid_q   <= 1'b0;
            discard_cnt_q <= 2'd0;
        end else begin
            discard_cnt_q <= discard_cnt_d;
            if (flush) begin
                ms_valid_q  <= 1'b0;
                buf_valid_q <= 1'b0;
            end else begin
                if (ms_allowin) begin
                    ms_valid_q <= es_to_ms_valid;
                end
                if (ms_allowin && es_to_ms_valid) begin
                    bus_q       <= es_to_ms_bus;
                    buf_valid_q <= 1'b0;
                end else if (wait_data && resp_ok && !ws_allowin) begin
                    rdata_buf_q <= data_sram_rdata;
                    buf_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
